bft_leaf_sender: RTL and testbench

Host-side sender for a single leaf of the BFT packet network. It converts a 32-bit valid/ack word stream into 49-bit BFT packets addressed to one configurable leaf input port. It enforces the leaf interface's credit (freespace) flow control by consuming freespace-update packets returned from that leaf. It drives the same packet bus that a leaf shell receives on its `din_leaf_bft2interface` input.

---
 rtl/bft_leaf_sender.sv | 120 ++++++++++++
 tb/tb_bft_leaf_sender.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bft_leaf_sender.sv
// Host-side BFT leaf sender: packs 32-bit words into 49-bit packets and enforces leaf credit flow control.
// Optional packet counter output enabled by defining BFT_SENDER_PKTCNT_EN.
module bft_leaf_sender #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dest_port,
  input  logic [PAYLOAD_BITS-1:0]       din,
  input  logic                          vld_in,
  output logic                          ack_out,
  input  logic [PACKET_BITS-1:0]        din_bft2sender,
  output logic [PACKET_BITS-1:0]        dout_sender2bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credit
`ifdef BFT_SENDER_PKTCNT_EN
  ,
  output logic [31:0]                   pkt_count
`endif
);

  localparam int CRED_W     = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_W      = NUM_BRAM_ADDR_BITS + 2;
  localparam int MAX_CREDIT = 1 << NUM_BRAM_ADDR_BITS;
  localparam int PORT_LSB   = PAYLOAD_BITS + NUM_ADDR_BITS;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_NOCRED = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                        state_reg, state_next;
  logic [CRED_W-1:0]             credit_reg, credit_next;
  logic [NUM_BRAM_ADDR_BITS-1:0] wr_ptr_reg;
  logic [PACKET_BITS-1:0]        dout_reg;
  logic                          accept;
  logic                          upd_valid;
  logic [CRED_W-1:0]             upd_n;
  logic [SUM_W-1:0]              credit_sum;
  logic [NUM_ADDR_BITS-1:0]      slot_addr;

  assign accept  = vld_in & (credit_reg != '0) & ~resend & (state_reg == S_RUN);
  assign ack_out = accept & ~reset;

  // Freespace updates arrive on the control port (port 0) of the return bus.
  assign upd_valid = din_bft2sender[PACKET_BITS-1] &
                     (din_bft2sender[PORT_LSB +: NUM_PORT_BITS] == '0);
  assign upd_n     = upd_valid ? din_bft2sender[CRED_W-1:0] : '0;

  // One extra bit of headroom lets an oversized update be detected and clamped.
  always_comb begin
    credit_sum  = SUM_W'(credit_reg) - SUM_W'(accept) + SUM_W'(upd_n);
    credit_next = credit_reg;
    if (credit_sum > SUM_W'(MAX_CREDIT)) begin
      credit_next = CRED_W'(MAX_CREDIT);
    end else begin
      credit_next = CRED_W'(credit_sum);
    end
  end

  always_comb begin
    state_next = state_reg;
    if (resend) begin
      state_next = S_HOLD;
    end else begin
      case (state_reg)
        S_RUN:    if (credit_next == '0) state_next = S_NOCRED;
        S_NOCRED: if (credit_next != '0) state_next = S_RUN;
        S_HOLD:   state_next = (credit_next != '0) ? S_RUN : S_NOCRED;
        default:  state_next = S_RUN;
      endcase
    end
  end

  assign slot_addr = NUM_ADDR_BITS'(wr_ptr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_RUN;
      credit_reg <= CRED_W'(MAX_CREDIT);
      wr_ptr_reg <= '0;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        dout_reg   <= {1'b1, dest_leaf, dest_port, slot_addr, din};
      end else begin
        dout_reg   <= '0;
      end
    end
  end

  // A packet registered just before resend rises is dropped, not replayed.
  assign dout_sender2bft = resend ? '0 : dout_reg;
  assign credit          = credit_reg;

`ifdef BFT_SENDER_PKTCNT_EN
  logic [31:0] pkt_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_reg <= '0;
    end else if (accept) begin
      pkt_count_reg <= pkt_count_reg + 32'd1;
    end
  end

  assign pkt_count = pkt_count_reg;
`endif

endmodule

// File: tb/tb_bft_leaf_sender.sv
// Scoreboard bench for bft_leaf_sender: driver runs a credit/slot reference model, monitor checks dout.
module tb_bft_leaf_sender;

  localparam int RUN = 0, NOCRED = 1, HOLD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dest_leaf;
  logic [3:0]  dest_port;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [48:0] din_bft2sender;
  logic [48:0] dout_sender2bft;
  logic        resend;
  logic [7:0]  credit;
`ifdef BFT_SENDER_PKTCNT_EN
  logic [31:0] pkt_count;
`endif

  bft_leaf_sender dut (
    .clk(clk), .reset(reset), .dest_leaf(dest_leaf), .dest_port(dest_port),
    .din(din), .vld_in(vld_in), .ack_out(ack_out),
    .din_bft2sender(din_bft2sender), .dout_sender2bft(dout_sender2bft),
    .resend(resend), .credit(credit)
`ifdef BFT_SENDER_PKTCNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; logic [48:0] pkt; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int m_cred, m_ptr, m_state, m_cnt;
  int acc_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [48:0] upd_pkt(input int n);
    logic [48:0] p;
    p = '0;
    p[48] = 1'b1;
    p[47:43] = 5'(($urandom) % 32);
    p[7:0] = 8'(n);
    return p;
  endfunction

  task automatic model_reset();
    m_cred = 128; m_ptr = 0; m_state = RUN; m_cnt = 0;
  endtask

  // Entered and left at posedge+1: drive one cycle, check, advance model.
  task automatic drive(input bit v, input logic [31:0] d, input logic [4:0] l,
                       input logic [3:0] p, input logic [48:0] ret, input bit rs);
    bit e_ack;
    int n, cn;
    logic [6:0] slot;
    exp_t e;
    vld_in = v; din = d; dest_leaf = l; dest_port = p;
    din_bft2sender = ret; resend = rs;
    #1;
    e_ack = v && (m_cred != 0) && !rs && (m_state == RUN);
    chk("ack_out", 64'(ack_out), 64'(e_ack));
    chk("credit", 64'(credit), 64'(m_cred));
`ifdef BFT_SENDER_PKTCNT_EN
    chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
`endif
    if (ack_out) acc_cnt++;
    if (e_ack) begin
      slot = 7'(m_ptr);
      e.tag = cyc + 1;
      e.pkt = {1'b1, l, p, slot, d};
      sb.push_back(e);
      m_ptr = (m_ptr + 1) % 128;
      m_cnt++;
    end
    n = (ret[48] && ret[42:39] == 4'd0) ? int'(ret[7:0]) : 0;
    cn = m_cred - (e_ack ? 1 : 0) + n;
    if (cn > 128) cn = 128;
    if (rs) m_state = HOLD;
    else if (m_state == HOLD) m_state = (cn != 0) ? RUN : NOCRED;
    else m_state = (cn != 0) ? RUN : NOCRED;
    m_cred = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 32'h0, 5'd0, 4'd1, 49'h0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle while a packet is on the bus.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("dout_async_reset", 64'(dout_sender2bft), 64'h0);
    chk("ack_in_reset", 64'(ack_out), 64'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("credit_after_reset", 64'(credit), 64'd128);
`ifdef BFT_SENDER_PKTCNT_EN
    chk("pkt_count_after_reset", 64'(pkt_count), 64'd0);
`endif
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [48:0] req;
    exp_t e;
    req = '0;
    if (sb.size() > 0 && sb[0].tag < cyc) begin
      checks++; errors++;
      $display("FAIL dout_missing cyc=%0d actual=none required=%h", cyc, sb[0].pkt);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      e = sb.pop_front();
      req = resend ? 49'h0 : e.pkt;
      $display("pkt cyc=%0d resend=%0b dout=%h req=%h", cyc, resend, dout_sender2bft, req);
    end
    if (reset) req = '0;
    chk("dout", 64'(dout_sender2bft), 64'(req));
  end

  initial begin
    bit rs;
    int rs_left;
    int kind;
    logic [48:0] ret;
    reset = 1'b1; vld_in = 1'b1; din = '0; dest_leaf = '0; dest_port = 4'd1;
    din_bft2sender = '0; resend = 1'b0;
    model_reset();
    acc_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 64'(ack_out), 64'h0);
    chk("reset_dout", 64'(dout_sender2bft), 64'h0);
    chk("reset_credit", 64'(credit), 64'd128);
    reset = 1'b0;

    // Five back-to-back words, slots 0..4
    for (int i = 0; i < 5; i++) drive(1, 32'hA0 + 32'(i), 5'd3, 4'd2, 49'h0, 0);
    idle(1);
    chk("credit_123", 64'(credit), 64'd123);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) drive(1, $urandom, 5'd7, 4'd5, 49'h0, 0);
    do_reset();

    // Exhaust the credit: 130 offered, 128 accepted
    acc_cnt = 0;
    for (int i = 0; i < 130; i++) drive(1, $urandom, 5'd3, 4'd2, 49'h0, 0);
    chk("accepted_128", 64'(acc_cnt), 64'd128);
    chk("credit_zero", 64'(credit), 64'd0);

    // Update n=64 at zero credit
    acc_cnt = 0;
    drive(1, $urandom, 5'd3, 4'd2, upd_pkt(64), 0);
    chk("credit_64", 64'(credit), 64'd64);
    chk("ack_after_update", 64'(ack_out), 64'd1);
    for (int i = 0; i < 69; i++) drive(1, $urandom, 5'd3, 4'd2, 49'h0, 0);
    chk("accepted_64", 64'(acc_cnt), 64'd64);

    // Simultaneous accept and update at credit 10
    drive(0, 32'h0, 5'd0, 4'd1, upd_pkt(10), 0);
    drive(1, 32'h1234_5678, 5'd9, 4'd15, upd_pkt(1), 0);
    chk("credit_stays_10", 64'(credit), 64'd10);

    // Resend for four cycles, with an update applied while held
    drive(1, 32'hCAFE_0001, 5'd1, 4'd1, 49'h0, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 32'hDEAD_0000 + 32'(i), 5'd1, 4'd1, (i == 1) ? upd_pkt(2) : 49'h0, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'hBEEF_0000 + 32'(i), 5'd1, 4'd1, 49'h0, 0);

    // Randomised traffic
    rs_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rs_left == 0 && $urandom_range(0, 99) < 4) rs_left = $urandom_range(1, 4);
      rs = (rs_left > 0);
      if (rs_left > 0) rs_left--;
      ret = '0;
      if ($urandom_range(0, 99) < 12 && !(m_state == HOLD && !rs)) begin
        kind = $urandom_range(0, 9);
        ret = upd_pkt((kind == 0) ? 200 : $urandom_range(0, 12));
        if (kind == 1) ret[42:39] = 4'($urandom_range(1, 15));
        if (kind == 2) ret[48] = 1'b0;
      end
      drive($urandom_range(0, 99) < 75, $urandom, 5'($urandom), 4'($urandom_range(1, 15)), ret, rs);
    end

    do_reset();
    drive(1, 32'h0000_5555, 5'd2, 4'd3, 49'h0, 0);
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
